// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: boots the external PC, fetches over a req/ack memory port and hands words to decode.
// Define FETCH_SEQ_MISALIGN_CHK_EN to halt on misaligned redirects instead of silently aligning them.
module fetch_sequencer #(
  parameter int            WL           = 32,
  parameter logic [WL-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [WL-1:0] pc_q,
  output logic          pc_en,
  output logic [WL-1:0] pc_next,
  output logic          imem_req,
  output logic [WL-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [WL-1:0] imem_rdata,
  output logic          instr_valid,
  output logic [WL-1:0] instr,
  output logic [WL-1:0] instr_pc,
  input  logic          dec_ready,
  input  logic          redir,
  input  logic [WL-1:0] redir_target,
  output logic          misalign_err
);

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT,
    ISSUE,
    HALT
  } state_t;

  localparam logic [WL-1:0] PC_STEP = WL'(4);

`ifdef FETCH_SEQ_MISALIGN_CHK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  state_t        r_state;
  state_t        w_stateNext;
  logic [WL-1:0] r_addr;
  logic [WL-1:0] r_instr;
  logic [WL-1:0] r_instrPc;
  logic          r_redirPend;
  logic [WL-1:0] r_redirTarget;

  logic [WL-1:0] w_redirAligned;
  logic          w_badRedir;
  logic          w_launch;
  logic          w_capture;
  logic          w_latchRedir;

  assign w_redirAligned = {redir_target[WL-1:2], 2'b00};
  assign w_badRedir     = MISALIGN_CHK & redir & (|redir_target[1:0]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A redirect always wins over the memory response; a pending redirect
  // from earlier in WAIT turns the ack into a pure "request retired" event.
  always_comb begin
    w_stateNext  = r_state;
    pc_en        = 1'b0;
    pc_next      = '0;
    imem_req     = 1'b0;
    imem_addr    = '0;
    w_launch     = 1'b0;
    w_capture    = 1'b0;
    w_latchRedir = 1'b0;

    case (r_state)
      BOOT: begin
        pc_en       = 1'b1;
        pc_next     = RESET_VECTOR;
        w_stateNext = FETCH;
      end

      FETCH: begin
        if (w_badRedir) begin
          w_stateNext = HALT;
        end else if (redir) begin
          pc_en   = 1'b1;
          pc_next = w_redirAligned;
        end else if (EN) begin
          imem_req    = 1'b1;
          imem_addr   = pc_q;
          w_launch    = 1'b1;
          w_stateNext = WAIT;
        end
      end

      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = r_addr;
        if (w_badRedir) begin
          w_stateNext = HALT;
        end else if (imem_ack) begin
          pc_en       = 1'b1;
          w_stateNext = FETCH;
          if (redir) begin
            pc_next = w_redirAligned;
          end else if (r_redirPend) begin
            pc_next = r_redirTarget;
          end else begin
            pc_next     = pc_q + PC_STEP;
            w_capture   = 1'b1;
            w_stateNext = ISSUE;
          end
        end else if (redir) begin
          w_latchRedir = 1'b1;
        end
      end

      ISSUE: begin
        if (w_badRedir) begin
          w_stateNext = HALT;
        end else if (redir) begin
          pc_en       = 1'b1;
          pc_next     = w_redirAligned;
          w_stateNext = FETCH;
        end else if (dec_ready) begin
          w_stateNext = FETCH;
        end
      end

      HALT: begin
        w_stateNext = HALT;
      end

      default: begin
        w_stateNext = BOOT;
      end
    endcase

    if (RST) begin
      pc_en     = 1'b0;
      pc_next   = '0;
      imem_req  = 1'b0;
      imem_addr = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr        <= '0;
      r_instr       <= '0;
      r_instrPc     <= '0;
      r_redirPend   <= 1'b0;
      r_redirTarget <= '0;
    end else begin
      if (w_launch) begin
        r_addr      <= pc_q;
        r_redirPend <= 1'b0;
      end
      if (w_latchRedir) begin
        r_redirPend   <= 1'b1;
        r_redirTarget <= w_redirAligned;
      end
      if (w_capture) begin
        r_instr   <= imem_rdata;
        r_instrPc <= pc_q;
      end
    end
  end

  assign instr_valid = (r_state == ISSUE);
  assign instr       = r_instr;
  assign instr_pc    = r_instrPc;

`ifdef FETCH_SEQ_MISALIGN_CHK_EN
  logic r_misalignErr;

  // HALT is only reachable through a rejected redirect, so entering it marks the error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_misalignErr <= 1'b0;
    end else if (w_stateNext == HALT) begin
      r_misalignErr <= 1'b1;
    end
  end

  assign misalign_err = r_misalignErr;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: boot, sequential fetch, wrap, redirects, squash, misalign and reset.
module tb_fetch_sequencer;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [31:0] pc_q;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        redir;
  logic [31:0] redir_target;
  logic        misalign_err;

  int nChecks = 0;
  int nPass   = 0;

  fetch_sequencer #(
    .WL(32),
    .RESET_VECTOR(32'h0000_0100)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .pc_q(pc_q),
    .pc_en(pc_en),
    .pc_next(pc_next),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .dec_ready(dec_ready),
    .redir(redir),
    .redir_target(redir_target),
    .misalign_err(misalign_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External PC register the sequencer drives through pc_en/pc_next.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_q <= '0;
    else if (pc_en) pc_q <= pc_next;
  end

  task automatic test_reset();
    @(negedge CLK); #1;
    nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL rst_pc_en got %0b exp 0", pc_en); else nPass++;
    nChecks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_imem_req got %0b exp 0", imem_req); else nPass++;
    nChecks++; if (instr_valid !== 1'b0) $display("[TB] FAIL rst_instr_valid got %0b exp 0", instr_valid); else nPass++;
    nChecks++; if (misalign_err !== 1'b0) $display("[TB] FAIL rst_misalign_err got %0b exp 0", misalign_err); else nPass++;
    nChecks++; if (pc_next !== 32'h0) $display("[TB] FAIL rst_pc_next got %h exp 0", pc_next); else nPass++;
    @(negedge CLK); RST = 1'b0; #1;
    nChecks++; if (pc_en !== 1'b1) $display("[TB] FAIL boot_pc_en got %0b exp 1", pc_en); else nPass++;
    nChecks++; if (pc_next !== 32'h100) $display("[TB] FAIL boot_pc_next got %h exp 100", pc_next); else nPass++;
    @(negedge CLK); EN = 1'b0; #1;
    nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL boot_once got %0b exp 0", pc_en); else nPass++;
    nChecks++; if (imem_req !== 1'b0) $display("[TB] FAIL idle_no_req got %0b exp 0", imem_req); else nPass++;
    @(negedge CLK); EN = 1'b1; #1;
    nChecks++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req got %0b exp 1", imem_req); else nPass++;
    nChecks++; if (imem_addr !== 32'h100) $display("[TB] FAIL first_addr got %h exp 100", imem_addr); else nPass++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); EN = 1'b0; #1;
      nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("[TB] FAIL wait_hold req=%0b addr=%h exp 1/100", imem_req, imem_addr); else nPass++;
      nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL wait_pc_en got %0b exp 0", pc_en); else nPass++;
    end
    @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'h2002_0005; #1;
    nChecks++; if (pc_en !== 1'b1) $display("[TB] FAIL ack_pc_en got %0b exp 1", pc_en); else nPass++;
    nChecks++; if (pc_next !== 32'h104) $display("[TB] FAIL ack_pc_next got %h exp 104", pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b0; #1;
    nChecks++; if (instr_valid !== 1'b1) $display("[TB] FAIL issue_valid got %0b exp 1", instr_valid); else nPass++;
    nChecks++; if (instr !== 32'h2002_0005) $display("[TB] FAIL issue_instr got %h exp 20020005", instr); else nPass++;
    nChecks++; if (instr_pc !== 32'h100) $display("[TB] FAIL issue_pc got %h exp 100", instr_pc); else nPass++;
    nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL issue_pc_en got %0b exp 0", pc_en); else nPass++;
    @(negedge CLK); dec_ready = 1'b1; #1;
    nChecks++; if (instr_valid !== 1'b1 || instr !== 32'h2002_0005) $display("[TB] FAIL issue_hold valid=%0b instr=%h exp 1/20020005", instr_valid, instr); else nPass++;
    @(negedge CLK); dec_ready = 1'b0; #1;
    nChecks++; if (instr_valid !== 1'b0) $display("[TB] FAIL bubble_valid got %0b exp 0", instr_valid); else nPass++;
    nChecks++; if (pc_q !== 32'h104) $display("[TB] FAIL seq_pc_q got %h exp 104", pc_q); else nPass++;
  endtask

  task automatic test_wrap();
    @(negedge CLK); redir = 1'b1; redir_target = 32'hFFFF_FFFC; EN = 1'b1; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'hFFFF_FFFC) $display("[TB] FAIL fetch_redir en=%0b next=%h exp 1/fffffffc", pc_en, pc_next); else nPass++;
    nChecks++; if (imem_req !== 1'b0) $display("[TB] FAIL fetch_redir_req got %0b exp 0", imem_req); else nPass++;
    @(negedge CLK); redir = 1'b0; #1;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_req req=%0b addr=%h exp 1/fffffffc", imem_req, imem_addr); else nPass++;
    @(negedge CLK); EN = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h0) $display("[TB] FAIL wrap_next en=%0b next=%h exp 1/0", pc_en, pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b1; #1;
    nChecks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'hCAFE_0001) $display("[TB] FAIL wrap_issue pc=%h instr=%h exp fffffffc/cafe0001", instr_pc, instr); else nPass++;
    @(negedge CLK); dec_ready = 1'b0; #1;
  endtask

  task automatic test_redirect_wait();
    @(negedge CLK); EN = 1'b1; #1;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL rw_req req=%0b addr=%h exp 1/0", imem_req, imem_addr); else nPass++;
    @(negedge CLK); EN = 1'b0; redir = 1'b1; redir_target = 32'h400; #1;
    nChecks++; if (pc_en !== 1'b0 || imem_req !== 1'b1) $display("[TB] FAIL rw_latch en=%0b req=%0b exp 0/1", pc_en, imem_req); else nPass++;
    @(negedge CLK); redir = 1'b0; #1;
    nChecks++; if (pc_en !== 1'b0 || imem_addr !== 32'h0) $display("[TB] FAIL rw_hold en=%0b addr=%h exp 0/0", pc_en, imem_addr); else nPass++;
    @(negedge CLK); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h400) $display("[TB] FAIL rw_ack en=%0b next=%h exp 1/400", pc_en, pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; EN = 1'b1; #1;
    nChecks++; if (instr_valid !== 1'b0) $display("[TB] FAIL rw_discard got %0b exp 0", instr_valid); else nPass++;
    nChecks++; if (imem_addr !== 32'h400) $display("[TB] FAIL rw_next_addr got %h exp 400", imem_addr); else nPass++;
    @(negedge CLK); EN = 1'b0; redir = 1'b1; redir_target = 32'h500; #1;
    @(negedge CLK); redir_target = 32'h600; #1;
    @(negedge CLK); redir = 1'b0; imem_ack = 1'b1; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h600) $display("[TB] FAIL newest_wins en=%0b next=%h exp 1/600", pc_en, pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; EN = 1'b1; #1;
    nChecks++; if (imem_addr !== 32'h600) $display("[TB] FAIL newest_addr got %h exp 600", imem_addr); else nPass++;
    @(negedge CLK); EN = 1'b0; imem_ack = 1'b1; redir = 1'b1; redir_target = 32'h700; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h700) $display("[TB] FAIL coincide en=%0b next=%h exp 1/700", pc_en, pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; redir = 1'b0; #1;
    nChecks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("[TB] FAIL coincide_after valid=%0b req=%0b exp 0/0", instr_valid, imem_req); else nPass++;
  endtask

  task automatic test_squash();
    @(negedge CLK); EN = 1'b1; #1;
    @(negedge CLK); EN = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0055; #1;
    nChecks++; if (pc_next !== 32'h704) $display("[TB] FAIL sq_ack_next got %h exp 704", pc_next); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b0; redir = 1'b1; redir_target = 32'h80; #1;
    nChecks++; if (instr_valid !== 1'b1) $display("[TB] FAIL sq_valid_before got %0b exp 1", instr_valid); else nPass++;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h80) $display("[TB] FAIL sq_redir en=%0b next=%h exp 1/80", pc_en, pc_next); else nPass++;
    @(negedge CLK); redir = 1'b0; EN = 1'b1; #1;
    nChecks++; if (instr_valid !== 1'b0) $display("[TB] FAIL sq_valid_after got %0b exp 0", instr_valid); else nPass++;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("[TB] FAIL sq_next_fetch req=%0b addr=%h exp 1/80", imem_req, imem_addr); else nPass++;
    @(negedge CLK); EN = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0; #1;
    @(negedge CLK); imem_ack = 1'b0; dec_ready = 1'b1; #1;
    @(negedge CLK); dec_ready = 1'b0; #1;
  endtask

  task automatic test_misalign();
    @(negedge CLK); EN = 1'b0; redir = 1'b1; redir_target = 32'h402; #1;
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
    nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL mis_pc_en got %0b exp 0", pc_en); else nPass++;
    @(negedge CLK); redir = 1'b0; EN = 1'b1; #1;
    nChecks++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_err got %0b exp 1", misalign_err); else nPass++;
    nChecks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) $display("[TB] FAIL halt_outputs req=%0b en=%0b exp 0/0", imem_req, pc_en); else nPass++;
    @(negedge CLK); #1;
    nChecks++; if (imem_req !== 1'b0 || misalign_err !== 1'b1) $display("[TB] FAIL halt_sticky req=%0b err=%0b exp 0/1", imem_req, misalign_err); else nPass++;
`else
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h400) $display("[TB] FAIL mis_align en=%0b next=%h exp 1/400", pc_en, pc_next); else nPass++;
    @(negedge CLK); redir = 1'b0; EN = 1'b1; #1;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) $display("[TB] FAIL mis_fetch req=%0b addr=%h exp 1/400", imem_req, imem_addr); else nPass++;
    nChecks++; if (misalign_err !== 1'b0) $display("[TB] FAIL mis_err_tied got %0b exp 0", misalign_err); else nPass++;
`endif
    @(negedge CLK); EN = 1'b0; #1;
  endtask

  task automatic test_reset_midwait();
    @(negedge CLK); RST = 1'b1; #1;
    nChecks++; if (misalign_err !== 1'b0 || imem_req !== 1'b0) $display("[TB] FAIL rst2_clear err=%0b req=%0b exp 0/0", misalign_err, imem_req); else nPass++;
    @(negedge CLK); RST = 1'b0; #1;
    @(negedge CLK); EN = 1'b1; #1;
    @(negedge CLK); EN = 1'b0; #1;
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("[TB] FAIL mw_req req=%0b addr=%h exp 1/100", imem_req, imem_addr); else nPass++;
    #2 RST = 1'b1; #1;
    nChecks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) $display("[TB] FAIL mw_async req=%0b addr=%h exp 0/0", imem_req, imem_addr); else nPass++;
    nChecks++; if (pc_en !== 1'b0) $display("[TB] FAIL mw_async_pc_en got %0b exp 0", pc_en); else nPass++;
    @(negedge CLK); RST = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_2222; #1;
    nChecks++; if (pc_en !== 1'b1 || pc_next !== 32'h100) $display("[TB] FAIL mw_boot en=%0b next=%h exp 1/100", pc_en, pc_next); else nPass++;
    @(negedge CLK); #1;
    nChecks++; if (pc_en !== 1'b0 || imem_req !== 1'b0) $display("[TB] FAIL late_ack en=%0b req=%0b exp 0/0", pc_en, imem_req); else nPass++;
    @(negedge CLK); imem_ack = 1'b0; #1;
    nChecks++; if (instr_valid !== 1'b0) $display("[TB] FAIL late_ack_valid got %0b exp 0", instr_valid); else nPass++;
  endtask

  initial begin
    RST          = 1'b1;
    EN           = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    dec_ready    = 1'b0;
    redir        = 1'b0;
    redir_target = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_squash();
    test_misalign();
    test_reset_midwait();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
